// File: rtl/i2c_pkg.sv
// Shared constants for the I2C EEPROM responder and its companion blocks.
// The state encodings are plain localparams so that older code can still compare against them.
package i2c_pkg;

  localparam logic [6:0] DEFAULT_DEV_ADDR = 7'b1010000;
  localparam logic       I2C_ACK          = 1'b0;
  localparam logic       I2C_NACK         = 1'b1;

  localparam logic [3:0] ST_IDLE      = 4'd0;
  localparam logic [3:0] ST_CTRL      = 4'd1;
  localparam logic [3:0] ST_ACK_CTRL  = 4'd2;
  localparam logic [3:0] ST_WADDR     = 4'd3;
  localparam logic [3:0] ST_ACK_WADDR = 4'd4;
  localparam logic [3:0] ST_WDATA     = 4'd5;
  localparam logic [3:0] ST_ACK_WDATA = 4'd6;
  localparam logic [3:0] ST_RDATA     = 4'd7;
  localparam logic [3:0] ST_RACK      = 4'd8;
  localparam logic [3:0] ST_IGNORE    = 4'd9;

endpackage

// File: rtl/i2c_eeprom_responder_if.sv
// Bus-side signals of the EEPROM responder: raw SCL/SDA in, open-drain enable out,
// and the write-commit side channel.
interface i2c_eeprom_responder_if #(
  parameter int ADDR_W = 8
);
  logic              scl_in;
  logic              sda_in;
  logic              sda_oe;
  logic              busy;
  logic              wr_strobe;
  logic [ADDR_W-1:0] wr_addr;
  logic [7:0]        wr_data;

  modport master (
    output scl_in, sda_in,
    input  sda_oe, busy, wr_strobe, wr_addr, wr_data
  );

  modport slave (
    input  scl_in, sda_in,
    output sda_oe, busy, wr_strobe, wr_addr, wr_data
  );
endinterface

// File: rtl/i2c_line_sync.sv
// Synchronises SCL/SDA into the system clock domain and flags SCL edges, START and STOP.
// START/STOP need SCL high in both samples, so a simultaneous SCL+SDA change never fires them.
module i2c_line_sync #(
  parameter int SYNC_STAGES = 2
) (
  input  logic clk,
  input  logic rst,
  input  logic scl,
  input  logic sda,
  output logic sda_s,
  output logic scl_rise,
  output logic scl_fall,
  output logic start_det,
  output logic stop_det
);

  logic [SYNC_STAGES-1:0] scl_sync;
  logic [SYNC_STAGES-1:0] sda_sync;
  logic                   scl_d;
  logic                   sda_d;
  logic                   scl_s;

  // Reset to the idle-bus level so release from reset never looks like an edge.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      scl_sync <= '1;
      sda_sync <= '1;
      scl_d    <= 1'b1;
      sda_d    <= 1'b1;
    end else begin
      scl_sync <= {scl_sync[SYNC_STAGES-2:0], scl};
      sda_sync <= {sda_sync[SYNC_STAGES-2:0], sda};
      scl_d    <= scl_sync[SYNC_STAGES-1];
      sda_d    <= sda_sync[SYNC_STAGES-1];
    end
  end

  assign scl_s     = scl_sync[SYNC_STAGES-1];
  assign sda_s     = sda_sync[SYNC_STAGES-1];
  assign scl_rise  = scl_s & ~scl_d;
  assign scl_fall  = ~scl_s & scl_d;
  assign start_det = scl_s & scl_d & sda_d & ~sda_s;
  assign stop_det  = scl_s & scl_d & ~sda_d & sda_s;

endmodule

// File: rtl/i2c_eeprom_responder.sv
// 24C02-style I2C EEPROM target: byte/sequential write, random, current-address and
// sequential read over an oversampled SCL/SDA pair. SDA only moves after SCL falls.
module i2c_eeprom_responder
  import i2c_pkg::*;
#(
  parameter logic [6:0] DEV_ADDR    = DEFAULT_DEV_ADDR,
  parameter int         ADDR_W      = 8,
  parameter int         SYNC_STAGES = 2
) (
  input  logic                   clk,
  input  logic                   rst,
  i2c_eeprom_responder_if.slave  bus
);

  localparam int DEPTH = 2 ** ADDR_W;

  logic              sda_s;
  logic              scl_rise;
  logic              scl_fall;
  logic              start_det;
  logic              stop_det;

  logic [3:0]        state;
  logic [3:0]        bit_cnt;
  logic [7:0]        shift;
  logic [ADDR_W-1:0] ptr;
  logic [ADDR_W-1:0] ptr_inc;
  logic              byte_done;
  logic              mem_we;
  logic [7:0]        mem [DEPTH];

  i2c_line_sync #(
    .SYNC_STAGES (SYNC_STAGES)
  ) u_line_sync (
    .clk       (clk),
    .rst       (rst),
    .scl       (bus.scl_in),
    .sda       (bus.sda_in),
    .sda_s     (sda_s),
    .scl_rise  (scl_rise),
    .scl_fall  (scl_fall),
    .start_det (start_det),
    .stop_det  (stop_det)
  );

  assign ptr_inc   = ptr + 1'b1;
  assign byte_done = scl_fall && (bit_cnt == 4'd8);
  assign mem_we    = (state == ST_WDATA) && byte_done;

  // Storage survives reset on purpose, like real EEPROM cells.
  always_ff @(posedge clk) begin
    if (mem_we) begin
      mem[ptr] <= shift;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state         <= ST_IDLE;
      bit_cnt       <= '0;
      shift         <= '0;
      ptr           <= '0;
      bus.sda_oe    <= 1'b0;
      bus.busy      <= 1'b0;
      bus.wr_strobe <= 1'b0;
      bus.wr_addr   <= '0;
      bus.wr_data   <= '0;
    end else begin
      bus.wr_strobe <= 1'b0;
      if (stop_det) begin
        state      <= ST_IDLE;
        bit_cnt    <= '0;
        bus.sda_oe <= 1'b0;
        bus.busy   <= 1'b0;
      end else if (start_det) begin
        state      <= ST_CTRL;
        bit_cnt    <= '0;
        bus.sda_oe <= 1'b0;
      end else begin
        case (state)
          ST_CTRL, ST_WADDR, ST_WDATA: begin
            if (scl_rise && (bit_cnt != 4'd8)) begin
              shift   <= {shift[6:0], sda_s};
              bit_cnt <= bit_cnt + 4'd1;
            end else if (byte_done) begin
              bit_cnt <= '0;
              if (state == ST_CTRL) begin
                if (shift[7:1] == DEV_ADDR) begin
                  state      <= ST_ACK_CTRL;
                  bus.sda_oe <= 1'b1;
                  bus.busy   <= 1'b1;
                end else begin
                  state    <= ST_IGNORE;
                  bus.busy <= 1'b0;
                end
              end else if (state == ST_WADDR) begin
                ptr        <= shift[ADDR_W-1:0];
                bus.sda_oe <= 1'b1;
                state      <= ST_ACK_WADDR;
              end else begin
                bus.wr_strobe <= 1'b1;
                bus.wr_addr   <= ptr;
                bus.wr_data   <= shift;
                ptr           <= ptr_inc;
                bus.sda_oe    <= 1'b1;
                state         <= ST_ACK_WDATA;
              end
            end
          end

          // shift[0] still holds the R/W bit of the control byte here.
          ST_ACK_CTRL: begin
            if (scl_fall) begin
              bit_cnt <= '0;
              if (shift[0]) begin
                shift      <= mem[ptr];
                bus.sda_oe <= ~mem[ptr][7];
                state      <= ST_RDATA;
              end else begin
                bus.sda_oe <= 1'b0;
                state      <= ST_WADDR;
              end
            end
          end

          ST_ACK_WADDR, ST_ACK_WDATA: begin
            if (scl_fall) begin
              bus.sda_oe <= 1'b0;
              state      <= ST_WDATA;
            end
          end

          // bit_cnt==0 on a fall means the byte was loaded at the RACK rise and bit 7 is still undriven.
          ST_RDATA: begin
            if (scl_rise) begin
              bit_cnt <= bit_cnt + 4'd1;
            end else if (scl_fall) begin
              if (bit_cnt == 4'd8) begin
                bus.sda_oe <= 1'b0;
                bit_cnt    <= '0;
                state      <= ST_RACK;
              end else if (bit_cnt == 4'd0) begin
                bus.sda_oe <= ~shift[7];
              end else begin
                shift      <= {shift[6:0], 1'b0};
                bus.sda_oe <= ~shift[6];
              end
            end
          end

          ST_RACK: begin
            if (scl_rise) begin
              ptr <= ptr_inc;
              if (sda_s == I2C_ACK) begin
                shift   <= mem[ptr_inc];
                bit_cnt <= '0;
                state   <= ST_RDATA;
              end else begin
                bus.sda_oe <= 1'b0;
                bus.busy   <= 1'b0;
                state      <= ST_IGNORE;
              end
            end
          end

          ST_IGNORE: begin
            bus.sda_oe <= 1'b0;
          end

          default: begin
            bus.sda_oe <= 1'b0;
          end
        endcase
      end
    end
  end

endmodule

// File: tb/tb_i2c_eeprom_responder.sv
// Directed bench for the I2C EEPROM responder: a bit-banged master on a wired-AND SDA line.
module tb_i2c_eeprom_responder;

  logic clk = 1'b0;
  logic rst;
  logic sda_m;
  int   checks = 0;
  int   errors = 0;
  int   strobe_cnt = 0;
  logic [7:0] strobe_addr [$];
  logic [7:0] strobe_data [$];
  logic       oe_seen = 1'b0;

  always #5 clk = ~clk;

  i2c_eeprom_responder_if #(.ADDR_W(8)) bus ();

  assign bus.sda_in = sda_m & ~bus.sda_oe;

  i2c_eeprom_responder #(
    .DEV_ADDR    (7'b1010000),
    .ADDR_W      (8),
    .SYNC_STAGES (2)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always @(negedge clk) begin
    if (bus.wr_strobe === 1'b1) begin
      strobe_cnt++;
      strobe_addr.push_back(bus.wr_addr);
      strobe_data.push_back(bus.wr_data);
    end
    if (bus.sda_oe === 1'b1) oe_seen = 1'b1;
  end

  initial begin
    #2000000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $display("CHECKS %0d ERRORS %0d", checks, errors + 1);
    $fatal(1, "[TB] timeout");
  end

  task automatic wait_q();
    repeat (5) @(negedge clk);
  endtask

  task automatic i2c_start();
    sda_m = 1'b1; wait_q();
    bus.scl_in = 1'b1; wait_q();
    sda_m = 1'b0; wait_q();
    bus.scl_in = 1'b0; wait_q();
  endtask

  task automatic i2c_stop();
    sda_m = 1'b0; wait_q();
    bus.scl_in = 1'b1; wait_q();
    sda_m = 1'b1; wait_q();
  endtask

  task automatic write_bit(input logic b);
    sda_m = b; wait_q();
    bus.scl_in = 1'b1; wait_q(); wait_q();
    bus.scl_in = 1'b0; wait_q();
  endtask

  task automatic read_bit(output logic b);
    sda_m = 1'b1; wait_q();
    bus.scl_in = 1'b1; wait_q();
    b = bus.sda_in; wait_q();
    bus.scl_in = 1'b0; wait_q();
  endtask

  task automatic write_byte(input logic [7:0] d, output logic ack);
    for (int i = 7; i >= 0; i--) write_bit(d[i]);
    read_bit(ack);
  endtask

  task automatic read_byte(input logic ack, output logic [7:0] d, output logic oe_at_ack);
    logic b;
    d = '0;
    for (int i = 0; i < 8; i++) begin
      read_bit(b);
      d = {d[6:0], b};
    end
    sda_m = ack; wait_q();
    bus.scl_in = 1'b1; wait_q();
    oe_at_ack = bus.sda_oe; wait_q();
    bus.scl_in = 1'b0; wait_q();
  endtask

  task automatic test_reset();
    rst = 1'b1; bus.scl_in = 1'b1; sda_m = 1'b1;
    repeat (3) @(negedge clk);
    checks++; if (bus.sda_oe !== 1'b0) begin errors++; $display("[TB] FAIL reset_sda_oe: got %b expected 0", bus.sda_oe); end
    checks++; if (bus.busy !== 1'b0) begin errors++; $display("[TB] FAIL reset_busy: got %b expected 0", bus.busy); end
    checks++; if (bus.wr_strobe !== 1'b0) begin errors++; $display("[TB] FAIL reset_wr_strobe: got %b expected 0", bus.wr_strobe); end
    checks++; if (bus.wr_addr !== 8'h00) begin errors++; $display("[TB] FAIL reset_wr_addr: got %h expected 00", bus.wr_addr); end
    checks++; if (bus.wr_data !== 8'h00) begin errors++; $display("[TB] FAIL reset_wr_data: got %h expected 00", bus.wr_data); end
    rst = 1'b0;
    repeat (5) @(negedge clk);
  endtask

  task automatic test_byte_write();
    int   base;
    logic a0, a1, a2;
    base = strobe_cnt;
    i2c_start();
    write_byte(8'hA0, a0);
    checks++; if (bus.busy !== 1'b1) begin errors++; $display("[TB] FAIL bw_busy_active: got %b expected 1", bus.busy); end
    write_byte(8'h05, a1);
    write_byte(8'h3C, a2);
    i2c_stop();
    wait_q();
    checks++; if (a0 !== 1'b0) begin errors++; $display("[TB] FAIL bw_ack_ctrl: got %b expected 0", a0); end
    checks++; if (a1 !== 1'b0) begin errors++; $display("[TB] FAIL bw_ack_addr: got %b expected 0", a1); end
    checks++; if (a2 !== 1'b0) begin errors++; $display("[TB] FAIL bw_ack_data: got %b expected 0", a2); end
    checks++; if (strobe_cnt - base != 1) begin errors++; $display("[TB] FAIL bw_strobe_count: got %0d expected 1", strobe_cnt - base); end
    checks++; if (strobe_addr[base] !== 8'h05) begin errors++; $display("[TB] FAIL bw_wr_addr: got %h expected 05", strobe_addr[base]); end
    checks++; if (strobe_data[base] !== 8'h3C) begin errors++; $display("[TB] FAIL bw_wr_data: got %h expected 3c", strobe_data[base]); end
    checks++; if (bus.busy !== 1'b0) begin errors++; $display("[TB] FAIL bw_busy_after_stop: got %b expected 0", bus.busy); end
  endtask

  task automatic test_random_read();
    logic a;
    logic oe;
    logic [7:0] d;
    i2c_start(); write_byte(8'hA0, a); write_byte(8'h06, a); write_byte(8'h5A, a); i2c_stop();
    i2c_start(); write_byte(8'hA0, a); write_byte(8'h05, a);
    i2c_start(); write_byte(8'hA1, a);
    checks++; if (a !== 1'b0) begin errors++; $display("[TB] FAIL rr_ack_read_ctrl: got %b expected 0", a); end
    read_byte(1'b1, d, oe);
    i2c_stop();
    checks++; if (d !== 8'h3C) begin errors++; $display("[TB] FAIL rr_data: got %h expected 3c", d); end
    checks++; if (oe !== 1'b0) begin errors++; $display("[TB] FAIL rr_released_at_nack: got %b expected 0", oe); end
    i2c_start(); write_byte(8'hA1, a); read_byte(1'b1, d, oe); i2c_stop();
    checks++; if (d !== 8'h5A) begin errors++; $display("[TB] FAIL rr_current_addr: got %h expected 5a", d); end
  endtask

  task automatic test_seq_wrap();
    int   base;
    logic a;
    logic ack_any;
    logic oe;
    logic [7:0] d;
    logic [7:0] exp_a [3];
    logic [7:0] exp_d [3];
    exp_a = '{8'hFE, 8'hFF, 8'h00};
    exp_d = '{8'h11, 8'h22, 8'h33};
    base = strobe_cnt;
    ack_any = 1'b0;
    i2c_start();
    write_byte(8'hA0, a); ack_any |= a;
    write_byte(8'hFE, a); ack_any |= a;
    for (int i = 0; i < 3; i++) begin
      write_byte(exp_d[i], a); ack_any |= a;
    end
    i2c_stop();
    wait_q();
    checks++; if (ack_any !== 1'b0) begin errors++; $display("[TB] FAIL sw_acks: got %b expected 0", ack_any); end
    checks++; if (strobe_cnt - base != 3) begin errors++; $display("[TB] FAIL sw_strobe_count: got %0d expected 3", strobe_cnt - base); end
    for (int i = 0; i < 3; i++) begin
      checks++; if (strobe_addr[base+i] !== exp_a[i]) begin errors++; $display("[TB] FAIL sw_wr_addr[%0d]: got %h expected %h", i, strobe_addr[base+i], exp_a[i]); end
      checks++; if (strobe_data[base+i] !== exp_d[i]) begin errors++; $display("[TB] FAIL sw_wr_data[%0d]: got %h expected %h", i, strobe_data[base+i], exp_d[i]); end
    end
    i2c_start(); write_byte(8'hA0, a); write_byte(8'hFE, a);
    i2c_start(); write_byte(8'hA1, a);
    for (int i = 0; i < 3; i++) begin
      read_byte((i == 2) ? 1'b1 : 1'b0, d, oe);
      checks++; if (d !== exp_d[i]) begin errors++; $display("[TB] FAIL sr_data[%0d]: got %h expected %h", i, d, exp_d[i]); end
    end
    i2c_stop();
  endtask

  task automatic test_wrong_addr();
    int   base;
    logic a;
    base = strobe_cnt;
    i2c_start();
    oe_seen = 1'b0;
    write_byte(8'h90, a);
    checks++; if (a !== 1'b1) begin errors++; $display("[TB] FAIL wa_nack: got %b expected 1", a); end
    checks++; if (oe_seen !== 1'b0) begin errors++; $display("[TB] FAIL wa_sda_oe_idle: got %b expected 0", oe_seen); end
    checks++; if (bus.busy !== 1'b0) begin errors++; $display("[TB] FAIL wa_busy: got %b expected 0", bus.busy); end
    i2c_start();
    write_byte(8'hA0, a);
    checks++; if (a !== 1'b0) begin errors++; $display("[TB] FAIL wa_next_ack: got %b expected 0", a); end
    i2c_stop();
    checks++; if (strobe_cnt != base) begin errors++; $display("[TB] FAIL wa_no_strobe: got %0d expected %0d", strobe_cnt, base); end
  endtask

  task automatic test_stop_mid_byte();
    int   base;
    logic a;
    logic oe;
    logic [7:0] d;
    i2c_start(); write_byte(8'hA0, a); write_byte(8'h10, a); write_byte(8'h77, a); i2c_stop();
    base = strobe_cnt;
    i2c_start(); write_byte(8'hA0, a); write_byte(8'h10, a);
    write_bit(1'b1); write_bit(1'b0); write_bit(1'b1); write_bit(1'b0);
    i2c_stop();
    wait_q();
    checks++; if (strobe_cnt != base) begin errors++; $display("[TB] FAIL smb_no_strobe: got %0d expected %0d", strobe_cnt, base); end
    checks++; if (bus.busy !== 1'b0) begin errors++; $display("[TB] FAIL smb_busy: got %b expected 0", bus.busy); end
    i2c_start(); write_byte(8'hA0, a); write_byte(8'h10, a);
    i2c_start(); write_byte(8'hA1, a); read_byte(1'b1, d, oe); i2c_stop();
    checks++; if (d !== 8'h77) begin errors++; $display("[TB] FAIL smb_mem_kept: got %h expected 77", d); end
  endtask

  task automatic test_reset_rdata();
    logic a;
    logic oe;
    logic [7:0] d;
    i2c_start(); write_byte(8'hA0, a); write_byte(8'h05, a);
    i2c_start(); write_byte(8'hA1, a);
    checks++; if (bus.sda_oe !== 1'b1) begin errors++; $display("[TB] FAIL rst_rd_driving: got %b expected 1", bus.sda_oe); end
    @(negedge clk);
    rst = 1'b1;
    #1;
    checks++; if (bus.sda_oe !== 1'b0) begin errors++; $display("[TB] FAIL rst_rd_async_release: got %b expected 0", bus.sda_oe); end
    checks++; if (bus.busy !== 1'b0) begin errors++; $display("[TB] FAIL rst_rd_busy: got %b expected 0", bus.busy); end
    bus.scl_in = 1'b1; sda_m = 1'b1;
    repeat (5) @(negedge clk);
    rst = 1'b0;
    repeat (5) @(negedge clk);
    i2c_start(); write_byte(8'hA1, a); read_byte(1'b1, d, oe); i2c_stop();
    checks++; if (d !== 8'h33) begin errors++; $display("[TB] FAIL rst_rd_ptr_zero: got %h expected 33", d); end
  endtask

  initial begin
    bus.scl_in = 1'b1;
    sda_m      = 1'b1;
    rst        = 1'b1;
    test_reset();
    test_byte_write();
    test_random_read();
    test_seq_wrap();
    test_wrong_addr();
    test_stop_mid_byte();
    test_reset_rdata();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
